// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and helpers for the load/store unit
//
// Purpose : funct3 size encodings, FSM state type, lane count and the
//           size/alignment helpers used by load_store_unit and lsu_lane_align.
// Ports   : none (package)

package lsu_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    AW_BYTE,
    AW_HALF,
    AW_WORD
  } acc_width_t;

  // Unused funct3 codes (011/110/111) fall into the word case.
  function automatic acc_width_t size_width(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: size_width = AW_BYTE;
      SZ_H, SZ_HU: size_width = AW_HALF;
      default:     size_width = AW_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size_width(size))
      AW_HALF: is_misaligned = addr_lo[0];
      AW_WORD: is_misaligned = |addr_lo;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering for stores and load extension
//
// Purpose : combinational lane logic. Builds byte enables and replicated
//           store data from size/low address bits, and selects plus
//           sign/zero-extends the addressed lane of a read word.
//           Low address bits finer than the access size are ignored
//           (half uses addr_lo[1] only, word always uses lane 0).
// Ports   : size        in  3   funct3 access size
//           addr_lo     in  2   byte offset within the word
//           wdata       in  32  raw store data (rs2)
//           mem_rdata   in  32  full word from the bus
//           be          out 4   byte enables
//           lane_wdata  out 32  replicated store data
//           rdata_ext   out 32  extended load data

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]       size,
  input  logic [1:0]       addr_lo,
  input  logic [31:0]      wdata,
  input  logic [31:0]      mem_rdata,
  output logic [LANES-1:0] be,
  output logic [31:0]      lane_wdata,
  output logic [31:0]      rdata_ext
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        is_unsigned;

  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  assign is_unsigned = size[2];

  always_comb begin
    be         = '0;
    lane_wdata = '0;
    rdata_ext  = '0;
    case (size_width(size))
      AW_BYTE: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        rdata_ext  = is_unsigned ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      AW_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        rdata_ext  = mem_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage with a single-outstanding bus
//
// Purpose : executes loads/stores from the decode control signals using the
//           ALU result as the byte address. IDLE -> ACCESS -> RESP FSM, all
//           bus outputs registered. Stores win when rd_en and wr_en are both
//           set. Build option LSU_MISALIGN_TRAP_EN: misaligned half/word
//           requests skip the bus and respond with fault=1, rdata=0; when
//           not defined, fault is 0 and low address bits are ignored.
// Ports   : clk, rst_n (sync, active-low)
//           req_valid/req_ready, rd_en, wr_en, data_size, addr, wdata  request
//           resp_valid, rdata, fault                                   response
//           mem_req, mem_we, mem_be, mem_addr, mem_wdata               bus out
//           mem_ack, mem_rdata                                         bus in

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        data_size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [LANES-1:0]  mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("load_store_unit: DATA_W must be 32");
    end
  endgenerate

  lsu_state_t  state;
  logic        wr_q;
  logic [2:0]  size_q;
  logic [1:0]  addr_lo_q;

  logic [2:0]       al_size;
  logic [1:0]       al_addr_lo;
  logic [LANES-1:0] al_be;
  logic [31:0]      al_wdata;
  logic [31:0]      al_rdata;

  // One lane aligner serves both ends of the access: in IDLE it sees the
  // incoming request (to register bus outputs), afterwards the latched one
  // (to extend the returning read word).
  assign al_size    = (state == ST_IDLE) ? data_size  : size_q;
  assign al_addr_lo = (state == ST_IDLE) ? addr[1:0]  : addr_lo_q;

  lsu_lane_align u_align (
    .size       (al_size),
    .addr_lo    (al_addr_lo),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .be         (al_be),
    .lane_wdata (al_wdata),
    .rdata_ext  (al_rdata)
  );

  assign req_ready = (state == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic fault_q;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_q       <= 1'b0;
      size_q     <= SZ_W;
      addr_lo_q  <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      rdata      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q      <= wr_en;
            size_q    <= data_size;
            addr_lo_q <= addr[1:0];
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= al_wdata;
            rdata     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q   <= 1'b0;
`endif
            if (rd_en || wr_en) begin
`ifdef LSU_MISALIGN_TRAP_EN
              if (is_misaligned(data_size, addr[1:0])) begin
                fault_q    <= 1'b1;
                resp_valid <= 1'b1;
                state      <= ST_RESP;
              end else
`endif
              begin
                mem_req <= 1'b1;
                mem_we  <= wr_en;
                mem_be  <= al_be;
                state   <= ST_ACCESS;
              end
            end else begin
              // No-op request: respond without touching the bus.
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            rdata      <= wr_q ? '0 : al_rdata;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  data_size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .data_size  (data_size),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and run it to its response. Outputs are sampled on the
  // falling edge; mem_ack is raised in the ack_delay-th cycle that mem_req is
  // seen. With pulse set, req_valid is pulsed while the access is pending.
  logic        r_saw_req;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_rdata;
  logic        r_fault;
  int          r_lat;
  int          r_reqc;
  int          r_hold_err;

  task automatic txn(input logic rd, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int ack_delay, input logic [31:0] mrd, input logic pulse);
    r_saw_req = 1'b0; r_be = '0; r_addr = '0; r_wdata = '0; r_we = 1'b0;
    r_rdata = 32'hxxxx_xxxx; r_fault = 1'bx; r_lat = -1; r_reqc = 0; r_hold_err = 0;
    @(negedge clk);
    req_valid = 1'b1; rd_en = rd; wr_en = wr; data_size = sz; addr = a; wdata = wd;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      mem_ack = 1'b0; req_valid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
      if (mem_req) begin
        if (!r_saw_req) begin
          r_saw_req = 1'b1; r_be = mem_be; r_addr = mem_addr; r_wdata = mem_wdata; r_we = mem_we;
        end else if (mem_be !== r_be || mem_addr !== r_addr || mem_wdata !== r_wdata || mem_we !== r_we) begin
          r_hold_err++;
        end
        if (req_ready !== 1'b0) r_hold_err++;
        r_reqc++;
        if (r_reqc == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = mrd;
        end else if (pulse) begin
          req_valid = 1'b1; rd_en = 1'b1; wr_en = 1'b0; addr = 32'h0000_0200;
        end
      end
      if (resp_valid) begin
        r_rdata = rdata; r_fault = fault; r_lat = c;
        break;
      end
    end
    if (r_lat < 0) chk("timeout_no_resp", 32'(r_lat), 32'd0);
    @(negedge clk);
    chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0; data_size = 3'b010;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    // lw 0x100
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 1, 32'hDEAD_BEEF, 1'b0);
    chk("lw_be", {28'd0, r_be}, 32'h0000_000F);
    chk("lw_addr", r_addr, 32'h0000_0100);
    chk("lw_we", {31'd0, r_we}, 32'd0);
    chk("lw_latency", 32'(r_lat), 32'd2);
    chk("lw_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("lw_fault", {31'd0, r_fault}, 32'd0);

    // lb / lbu 0x103
    txn(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 1, 32'h8011_2233, 1'b0);
    chk("lb_be", {28'd0, r_be}, 32'h0000_0008);
    chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
    txn(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 1, 32'h8011_2233, 1'b0);
    chk("lbu_rdata", r_rdata, 32'h0000_0080);

    // sh 0x0A
    txn(1'b0, 1'b1, 3'b001, 32'h0000_000A, 32'h1234_ABCD, 1, 32'hFFFF_FFFF, 1'b0);
    chk("sh_we", {31'd0, r_we}, 32'd1);
    chk("sh_be", {28'd0, r_be}, 32'h0000_000C);
    chk("sh_addr", r_addr, 32'h0000_0008);
    chk("sh_wdata", r_wdata, 32'hABCD_ABCD);
    chk("sh_rdata", r_rdata, 32'd0);

    // sb 0x101 byte replication
    txn(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h7777_77A5, 1, 32'd0, 1'b0);
    chk("sb_be", {28'd0, r_be}, 32'h0000_0002);
    chk("sb_wdata", r_wdata, 32'hA5A5_A5A5);

    // lh / lhu upper half
    txn(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 1, 32'h8001_7FFF, 1'b0);
    chk("lh_be", {28'd0, r_be}, 32'h0000_000C);
    chk("lh_rdata", r_rdata, 32'hFFFF_8001);
    txn(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'd0, 1, 32'h8001_F00F, 1'b0);
    chk("lhu_lo_rdata", r_rdata, 32'h0000_F00F);

    // rd_en & wr_en both set -> store
    txn(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_0001, 1, 32'h1111_1111, 1'b0);
    chk("both_we", {31'd0, r_we}, 32'd1);
    chk("both_rdata", r_rdata, 32'd0);

    // size 011 treated as word
    txn(1'b1, 1'b0, 3'b011, 32'h0000_0104, 32'd0, 1, 32'h0123_4567, 1'b0);
    chk("sz011_be", {28'd0, r_be}, 32'h0000_000F);
    chk("sz011_rdata", r_rdata, 32'h0123_4567);

    // no-op request: no bus, response next cycle
    txn(1'b0, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 1, 32'd0, 1'b0);
    chk("noop_no_req", {31'd0, r_saw_req}, 32'd0);
    chk("noop_latency", 32'(r_lat), 32'd1);
    chk("noop_rdata", r_rdata, 32'd0);

    // lw with ack after 5 cycles, req_valid pulsed meanwhile
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 5, 32'h0BAD_F00D, 1'b1);
    chk("slow_req_cycles", 32'(r_reqc), 32'd5);
    chk("slow_hold_stable", 32'(r_hold_err), 32'd0);
    chk("slow_latency", 32'(r_lat), 32'd6);
    chk("slow_rdata", r_rdata, 32'h0BAD_F00D);
    chk("slow_addr", r_addr, 32'h0000_0040);

    // reset while in ACCESS
    @(negedge clk);
    req_valid = 1'b1; rd_en = 1'b1; wr_en = 1'b0; data_size = 3'b010; addr = 32'h0000_0500;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_in_access", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("rstmid_resp_later", {31'd0, resp_valid}, 32'd0);
    chk("rstmid_req_later", {31'd0, mem_req}, 32'd0);

    // misaligned word / half
`ifdef LSU_MISALIGN_TRAP_EN
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
    chk("mis_w_no_req", {31'd0, r_saw_req}, 32'd0);
    chk("mis_w_fault", {31'd0, r_fault}, 32'd1);
    chk("mis_w_rdata", r_rdata, 32'd0);
    chk("mis_w_latency", 32'(r_lat), 32'd1);
    txn(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
    chk("mis_h_fault", {31'd0, r_fault}, 32'd1);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'd0, 1, 32'h2222_3333, 1'b0);
    chk("aligned_w_fault", {31'd0, r_fault}, 32'd0);
    chk("aligned_w_rdata", r_rdata, 32'h2222_3333);
`else
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 1, 32'h4455_6677, 1'b0);
    chk("mis_w_req", {31'd0, r_saw_req}, 32'd1);
    chk("mis_w_be", {28'd0, r_be}, 32'h0000_000F);
    chk("mis_w_addr", r_addr, 32'h0000_0100);
    chk("mis_w_fault", {31'd0, r_fault}, 32'd0);
    chk("mis_w_rdata", r_rdata, 32'h4455_6677);
    txn(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'd0, 1, 32'h7F00_0000, 1'b0);
    chk("mis_h_be", {28'd0, r_be}, 32'h0000_000C);
    chk("mis_h_rdata", r_rdata, 32'h0000_7F00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
